wb_stage: RTL and testbench

- Write-back stage: the producing end of the register-bank write port (wb_we/wb_addr/wb_din) that the register-fetch stage consumes.
- Takes the MEM-stage result, aligns and extends load data (big-endian), and registers the write.
- Merges a second, late writer (mul/div or coprocessor results) through a small FIFO.
- Stalls the pipeline for one cycle when that FIFO is starved of free write slots.

---
 rtl/wb_stage_pkg.sv | 30 +++
 rtl/wb_aux_fifo.sv | 70 +++++++
 rtl/wb_stage.sv | 163 ++++++++++++++++
 tb/tb_wb_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// wb_stage_pkg
// Shared definitions for the write-back stage:
//   - load-control encodings carried on mem_ld_ctl_i
//   - datapath widths
//   - default aux FIFO depth and starvation limit
//   - the aux FIFO entry record
// ---------------------------------------------------------------------------
package wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    // Load-control codes; 6 and 7 are unused and behave like LD_ALU.
    localparam logic [2:0] LD_ALU = 3'd0;
    localparam logic [2:0] LD_W   = 3'd1;
    localparam logic [2:0] LD_B   = 3'd2;
    localparam logic [2:0] LD_BU  = 3'd3;
    localparam logic [2:0] LD_H   = 3'd4;
    localparam logic [2:0] LD_HU  = 3'd5;

    localparam int AUX_DEPTH_DEF  = 2;
    localparam int STARVE_MAX_DEF = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } aux_entry_t;

endpackage

// File: rtl/wb_aux_fifo.sv
// ---------------------------------------------------------------------------
// wb_aux_fifo
// Small synchronous FIFO holding late register writes (mul/div, coprocessor)
// until the write-back port has a free slot.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset (empties FIFO)
//   push, push_addr/din   enqueue request; ignored when full
//   pop                   dequeue request; ignored when empty
//   head_addr/din         entry at the read pointer (valid when !empty)
//   count                 registered occupancy, 0..DEPTH
//   empty                 count == 0
// ---------------------------------------------------------------------------
module wb_aux_fifo
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = AUX_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_addr,
    input  logic [DATA_W-1:0]            push_din,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_addr,
    output logic [DATA_W-1:0]            head_din,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    aux_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign do_push   = push && (count != CNT_W'(DEPTH));
    assign do_pop    = pop && !empty;
    assign head_addr = mem[rd_ptr].addr;
    assign head_din  = mem[rd_ptr].din;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; emptiness is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= '{addr: push_addr, din: push_din};
        end
    end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Write-back stage: aligns/extends big-endian load data, registers the
// register-bank write, and merges a late aux writer through a small FIFO.
// When the FIFO head has waited STARVE_MAX cycles behind pipe writes, the
// pipeline is frozen for one cycle so the head can drain.
//
// Ports:
//   clk, rst_i            clock, asynchronous active-high reset
//   mem_we_i/addr_i       MEM-stage write request and destination
//   mem_alu_i             ALU / pass-through result
//   mem_dmem_i            raw data-memory word
//   mem_ld_ctl_i          load type (LD_* in wb_stage_pkg)
//   mem_ba_i              byte address of the load
//   aux_valid_i/addr_i/din_i  late writer offer
//   aux_ready_o           aux FIFO can accept this cycle
//   stall_o               upstream freeze; MEM inputs ignored this cycle
//   wb_we_o/addr_o/din_o  registered register-bank write (also WB forward)
// ---------------------------------------------------------------------------
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int AUX_DEPTH  = AUX_DEPTH_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        mem_we_i,
    input  logic [4:0]  mem_addr_i,
    input  logic [31:0] mem_alu_i,
    input  logic [31:0] mem_dmem_i,
    input  logic [2:0]  mem_ld_ctl_i,
    input  logic [1:0]  mem_ba_i,
    input  logic        aux_valid_i,
    input  logic [4:0]  aux_addr_i,
    input  logic [31:0] aux_din_i,
    output logic        aux_ready_o,
    output logic        stall_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic [31:0] wb_din_o
);

    localparam int CNT_W = $clog2(AUX_DEPTH+1);
    localparam int SV_W  = $clog2(STARVE_MAX+1);

    function automatic logic signed [DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                          input logic       sgn);
        return {{(DATA_W-8){sgn & b[7]}}, b};
    endfunction

    function automatic logic signed [DATA_W-1:0] ext_half(input logic [15:0] h,
                                                          input logic        sgn);
        return {{(DATA_W-16){sgn & h[15]}}, h};
    endfunction

    logic [7:0]               ld_byte_p0;
    logic [15:0]              ld_half_p0;
    logic signed [DATA_W-1:0] ld_data_p0;
    logic                     pipe_wr_p0;

    logic [ADDR_W-1:0]        aux_head_addr;
    logic [DATA_W-1:0]        aux_head_din;
    logic [CNT_W-1:0]         aux_count;
    logic                     aux_empty;
    logic                     aux_push;
    logic                     aux_pop;

    logic [SV_W-1:0]          starve_cnt;
    logic                     stall_q;

    logic                     wb_we_p1;
    logic [ADDR_W-1:0]        wb_addr_p1;
    logic [DATA_W-1:0]        wb_din_p1;

    // ---- stage p0: MEM inputs, load alignment and write arbitration ----
    always_comb begin
        ld_byte_p0 = mem_dmem_i[31:24];
        case (mem_ba_i)
            2'd0:    ld_byte_p0 = mem_dmem_i[31:24];
            2'd1:    ld_byte_p0 = mem_dmem_i[23:16];
            2'd2:    ld_byte_p0 = mem_dmem_i[15:8];
            default: ld_byte_p0 = mem_dmem_i[7:0];
        endcase
        ld_half_p0 = mem_ba_i[1] ? mem_dmem_i[15:0] : mem_dmem_i[31:16];

        ld_data_p0 = mem_alu_i;
        case (mem_ld_ctl_i)
            LD_W:    ld_data_p0 = mem_dmem_i;
            LD_B:    ld_data_p0 = ext_byte(ld_byte_p0, 1'b1);
            LD_BU:   ld_data_p0 = ext_byte(ld_byte_p0, 1'b0);
            LD_H:    ld_data_p0 = ext_half(ld_half_p0, 1'b1);
            LD_HU:   ld_data_p0 = ext_half(ld_half_p0, 1'b0);
            default: ld_data_p0 = mem_alu_i;
        endcase
    end

    // A stall cycle blocks the pipe write so the aux head gets the port.
    assign pipe_wr_p0  = mem_we_i && (mem_addr_i != '0) && !stall_q;
    assign aux_pop     = !pipe_wr_p0 && !aux_empty;
    assign aux_ready_o = (aux_count < CNT_W'(AUX_DEPTH));
    assign aux_push    = aux_valid_i && aux_ready_o;

    wb_aux_fifo #(
        .DEPTH (AUX_DEPTH)
    ) u_aux_fifo (
        .clk       (clk),
        .rst       (rst_i),
        .push      (aux_push),
        .push_addr (aux_addr_i),
        .push_din  (aux_din_i),
        .pop       (aux_pop),
        .head_addr (aux_head_addr),
        .head_din  (aux_head_din),
        .count     (aux_count),
        .empty     (aux_empty)
    );

    // Starvation counter counts cycles the head waits; the stall is a
    // one-cycle pulse that can never repeat back to back.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else begin
            stall_q <= (starve_cnt == SV_W'(STARVE_MAX)) && !stall_q;
            if (aux_empty || aux_pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != SV_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + SV_W'(1);
            end
        end
    end

    // ---- stage p1: registered register-bank write ----
    // Aux entries addressed to r0 are popped but produce no write; when
    // nothing writes, address and data hold their last values.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wb_we_p1   <= 1'b0;
            wb_addr_p1 <= '0;
            wb_din_p1  <= '0;
        end else if (pipe_wr_p0) begin
            wb_we_p1   <= 1'b1;
            wb_addr_p1 <= mem_addr_i;
            wb_din_p1  <= ld_data_p0;
        end else if (aux_pop) begin
            wb_we_p1 <= (aux_head_addr != '0);
            if (aux_head_addr != '0) begin
                wb_addr_p1 <= aux_head_addr;
                wb_din_p1  <= aux_head_din;
            end
        end else begin
            wb_we_p1 <= 1'b0;
        end
    end

    assign stall_o   = stall_q;
    assign wb_we_o   = wb_we_p1;
    assign wb_addr_o = wb_addr_p1;
    assign wb_din_o  = wb_din_p1;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int AUX_DEPTH  = 2;
    localparam int STARVE_MAX = 8;
    localparam logic [31:0] DM = 32'h81A2C3F4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_we_i;
    logic [4:0]  mem_addr_i;
    logic [31:0] mem_alu_i;
    logic [31:0] mem_dmem_i;
    logic [2:0]  mem_ld_ctl_i;
    logic [1:0]  mem_ba_i;
    logic        aux_valid_i;
    logic [4:0]  aux_addr_i;
    logic [31:0] aux_din_i;
    logic        aux_ready_o;
    logic        stall_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_din_o;

    always #5 clk = ~clk;

    wb_stage #(
        .AUX_DEPTH  (AUX_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_alu_i    (mem_alu_i),
        .mem_dmem_i   (mem_dmem_i),
        .mem_ld_ctl_i (mem_ld_ctl_i),
        .mem_ba_i     (mem_ba_i),
        .aux_valid_i  (aux_valid_i),
        .aux_addr_i   (aux_addr_i),
        .aux_din_i    (aux_din_i),
        .aux_ready_o  (aux_ready_o),
        .stall_o      (stall_o),
        .wb_we_o      (wb_we_o),
        .wb_addr_o    (wb_addr_o),
        .wb_din_o     (wb_din_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got we/addr/din/rdy/stall=%h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] dut_out();
        return {wb_we_o, wb_addr_o, wb_din_o, aux_ready_o, stall_o};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_din;
    bit          last_acc;

    function automatic logic [31:0] ref_load(input logic [2:0] ctl, input logic [1:0] ba,
                                             input logic [31:0] dm, input logic [31:0] alu);
        longint v;
        int     sh;
        case (ctl)
            3'd1: return dm;
            3'd2, 3'd3: begin
                sh = 8 * (3 - int'(ba));
                v  = (longint'(dm) >> sh) % 256;
                if (ctl == 3'd2 && v >= 128) v -= 256;
                return 32'(v);
            end
            3'd4, 3'd5: begin
                v = ba[1] ? longint'(dm) % 65536 : longint'(dm) / 65536;
                if (ctl == 3'd4 && v >= 32768) v -= 65536;
                return 32'(v);
            end
            default: return alu;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_stall  = 0;
        m_we     = 0;
        m_addr   = '0;
        m_din    = '0;
    endtask

    function automatic logic [39:0] model_out();
        return {m_we, m_addr, m_din, (mq.size() < AUX_DEPTH), m_stall};
    endfunction

    task automatic model_step(input logic we, input logic [4:0] a, input logic [31:0] alu,
                              input logic [31:0] dm, input logic [2:0] ctl, input logic [1:0] ba,
                              input logic av, input logic [4:0] aa, input logic [31:0] ad);
        bit   nonempty;
        bit   ready;
        bit   popped;
        bit   nstall;
        ent_t e;
        nonempty = (mq.size() > 0);
        ready    = (mq.size() < AUX_DEPTH);
        popped   = 0;
        if (we && a != 0 && !m_stall) begin
            m_we = 1; m_addr = a; m_din = ref_load(ctl, ba, dm, alu);
        end else if (nonempty) begin
            e = mq.pop_front();
            popped = 1;
            if (e.a != 0) begin
                m_we = 1; m_addr = e.a; m_din = e.d;
            end else begin
                m_we = 0;
            end
        end else begin
            m_we = 0;
        end
        last_acc = av && ready;
        if (last_acc) mq.push_back('{a: aa, d: ad});
        nstall = (m_starve == STARVE_MAX) && !m_stall;
        if (nonempty && !popped) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        else m_starve = 0;
        m_stall = nstall;
    endtask

    // One clock: drive, advance model, check every output against the model.
    task automatic cyc(input string nm, input logic we, input logic [4:0] a, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [2:0] ctl, input logic [1:0] ba,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
        mem_we_i = we; mem_addr_i = a; mem_alu_i = alu; mem_dmem_i = dm;
        mem_ld_ctl_i = ctl; mem_ba_i = ba;
        aux_valid_i = av; aux_addr_i = aa; aux_din_i = ad;
        model_step(we, a, alu, dm, ctl, ba, av, aa, ad);
        @(posedge clk);
        #1;
        check(nm, dut_out(), model_out());
    endtask

    task automatic bubble(input string nm);
        cyc(nm, 1'b0, 5'd0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        mem_we_i = 0; mem_addr_i = 0; mem_alu_i = 0; mem_dmem_i = 0;
        mem_ld_ctl_i = 0; mem_ba_i = 0;
        aux_valid_i = 0; aux_addr_i = 0; aux_din_i = 0;
        rst_i = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        check("reset", dut_out(), 40'h2);
    endtask

    // ---------------- table of load-format vectors ----------------
    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic [2:0]  ctl;
        logic [1:0]  ba;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_din;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int   k;
        int   stall_first;
        int   stall_cnt;
        int   aux_k;
        bit   bad_seen;
        bit   seen_c;
        bit   acc_c;
        logic we_r;
        logic [4:0] a_r;

        tbl[0]  = '{1'b1, 5'd5,  32'h0,        3'd2, 2'd0, 1'b1, 5'd5,  32'hFFFFFF81};
        tbl[1]  = '{1'b1, 5'd5,  32'h0,        3'd3, 2'd3, 1'b1, 5'd5,  32'h000000F4};
        tbl[2]  = '{1'b1, 5'd5,  32'h0,        3'd4, 2'd2, 1'b1, 5'd5,  32'hFFFFC3F4};
        tbl[3]  = '{1'b1, 5'd5,  32'h0,        3'd5, 2'd0, 1'b1, 5'd5,  32'h000081A2};
        tbl[4]  = '{1'b1, 5'd5,  32'h0,        3'd1, 2'd2, 1'b1, 5'd5,  32'h81A2C3F4};
        tbl[5]  = '{1'b1, 5'd5,  32'h0,        3'd2, 2'd1, 1'b1, 5'd5,  32'hFFFFFFA2};
        tbl[6]  = '{1'b1, 5'd5,  32'h0,        3'd3, 2'd0, 1'b1, 5'd5,  32'h00000081};
        tbl[7]  = '{1'b1, 5'd5,  32'h0,        3'd4, 2'd1, 1'b1, 5'd5,  32'hFFFF81A2};
        tbl[8]  = '{1'b1, 5'd5,  32'h0,        3'd5, 2'd3, 1'b1, 5'd5,  32'h0000C3F4};
        tbl[9]  = '{1'b1, 5'd5,  32'h0,        3'd2, 2'd2, 1'b1, 5'd5,  32'hFFFFFFC3};
        tbl[10] = '{1'b1, 5'd6,  32'h12345678, 3'd0, 2'd1, 1'b1, 5'd6,  32'h12345678};
        tbl[11] = '{1'b1, 5'd7,  32'hCAFEBABE, 3'd6, 2'd0, 1'b1, 5'd7,  32'hCAFEBABE};
        tbl[12] = '{1'b1, 5'd8,  32'h0BADF00D, 3'd7, 2'd3, 1'b1, 5'd8,  32'h0BADF00D};
        tbl[13] = '{1'b1, 5'd0,  32'h55555555, 3'd1, 2'd0, 1'b0, 5'd8,  32'h0BADF00D};
        tbl[14] = '{1'b0, 5'd9,  32'h66666666, 3'd1, 2'd0, 1'b0, 5'd8,  32'h0BADF00D};
        tbl[15] = '{1'b1, 5'd31, 32'h0,        3'd4, 2'd3, 1'b1, 5'd31, 32'hFFFFC3F4};

        rst_i = 1'b1;
        #2;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            cyc("tbl_model", tbl[i].we, tbl[i].addr, tbl[i].alu, DM, tbl[i].ctl, tbl[i].ba,
                1'b0, 5'd0, 32'h0);
            check($sformatf("tbl[%0d]", i), dut_out(),
                  {tbl[i].exp_we, tbl[i].exp_addr, tbl[i].exp_din, 1'b1, 1'b0});
        end

        // Priority: pipe write wins, aux entry follows on the bubble.
        do_reset();
        cyc("prio0", 1'b1, 5'd3, 32'h11, DM, 3'd0, 2'd0, 1'b1, 5'd4, 32'h22);
        check("prio_pipe", dut_out(), {1'b1, 5'd3, 32'h11, 1'b1, 1'b0});
        bubble("prio1");
        check("prio_aux", dut_out(), {1'b1, 5'd4, 32'h22, 1'b1, 1'b0});

        // Backpressure: two entries fill the FIFO; third offer is held.
        do_reset();
        cyc("bp0", 1'b1, 5'd10, 32'h100, DM, 3'd0, 2'd0, 1'b1, 5'd7, 32'hAAAA0001);
        cyc("bp1", 1'b1, 5'd10, 32'h101, DM, 3'd0, 2'd0, 1'b1, 5'd8, 32'hAAAA0002);
        check("bp_full", {39'h0, aux_ready_o}, 40'h0);
        seen_c = 0;
        acc_c  = 0;
        for (int i = 0; i < 40 && !acc_c; i++) begin
            cyc("bp_hold", 1'b1, 5'd10, 32'h200 + i, DM, 3'd0, 2'd0, 1'b1, 5'd9, 32'hAAAA0003);
            acc_c = last_acc;
            if (wb_we_o && wb_addr_o == 5'd9 && wb_din_o == 32'hAAAA0003) seen_c = 1;
        end
        for (int i = 0; i < 6; i++) begin
            bubble("bp_drain");
            if (wb_we_o && wb_addr_o == 5'd9 && wb_din_o == 32'hAAAA0003) seen_c = 1;
        end
        check("bp_third_accepted", {39'h0, acc_c}, 40'h1);
        check("bp_third_written", {39'h0, seen_c}, 40'h1);

        // Starvation: one aux entry behind continuous pipe writes.
        do_reset();
        cyc("st0", 1'b1, 5'd11, 32'h1000, DM, 3'd0, 2'd0, 1'b1, 5'd12, 32'hA5A5A5A5);
        stall_first = -1; stall_cnt = 0; aux_k = -1; bad_seen = 0;
        for (k = 1; k <= 12; k++) begin
            cyc("st", 1'b1, 5'd11, 32'h1000 + k, DM, 3'd0, 2'd0, 1'b0, 5'd0, 32'h0);
            if (stall_o) begin
                stall_cnt++;
                if (stall_first < 0) stall_first = k;
            end
            if (wb_we_o && wb_addr_o == 5'd12 && wb_din_o == 32'hA5A5A5A5) aux_k = k;
            if (wb_we_o && wb_din_o == 32'h100A) bad_seen = 1;
        end
        check("st_first", 40'(stall_first), 40'd9);
        check("st_once", 40'(stall_cnt), 40'd1);
        check("st_aux_after", 40'(aux_k), 40'd10);
        check("st_blocked", {39'h0, bad_seen}, 40'h0);

        // r0: pipe write suppressed; aux r0 entries popped silently.
        do_reset();
        cyc("r0_pipe", 1'b1, 5'd0, 32'h55, DM, 3'd0, 2'd0, 1'b0, 5'd0, 32'h0);
        check("r0_pipe_nowe", {39'h0, wb_we_o}, 40'h0);
        cyc("r0_a", 1'b1, 5'd13, 32'h1, DM, 3'd0, 2'd0, 1'b1, 5'd0, 32'h77);
        cyc("r0_b", 1'b1, 5'd13, 32'h2, DM, 3'd0, 2'd0, 1'b1, 5'd0, 32'h78);
        check("r0_full", {39'h0, aux_ready_o}, 40'h0);
        bubble("r0_pop");
        check("r0_pop_nowe_ready", {38'h0, wb_we_o, aux_ready_o}, 40'h1);

        // Asynchronous reset while the FIFO holds two entries.
        do_reset();
        cyc("mr0", 1'b1, 5'd14, 32'h3, DM, 3'd0, 2'd0, 1'b1, 5'd14, 32'hBEEF0001);
        cyc("mr1", 1'b1, 5'd15, 32'h4, DM, 3'd0, 2'd0, 1'b1, 5'd15, 32'hBEEF0002);
        rst_i = 1'b1;
        #2;
        check("rst_async", dut_out(), 40'h2);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bubble("post_rst");
            check("post_rst_nowe", {39'h0, wb_we_o}, 40'h0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 500; i++) begin
            we_r = ($urandom_range(0, 3) != 0);
            a_r  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            cyc("rand", we_r, a_r, $urandom, $urandom, 3'($urandom), 2'($urandom),
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
